// File: rtl/pixel_frame_buffer_if.sv
// Writer, clear, swap and scanner signals of the double-buffered pixel store.
// The master drives requests and the scan column; the slave returns acks, status and pixel data.
interface pixel_frame_buffer_if #(
    parameter int N_COLS           = 8,
    parameter int N_ROWS           = 8,
    parameter int BITS_PER_CHANNEL = 8,
    parameter int COL_W            = $clog2(N_COLS),
    parameter int ROW_W            = $clog2(N_ROWS)
);
    localparam int PW = 3 * BITS_PER_CHANNEL;

    logic                    write_en;
    logic [COL_W+ROW_W-1:0]  pixel_addr;
    logic [PW-1:0]           pixel_value;
    logic [2:0]              chan_mask;
    logic                    write_ack;
    logic                    clear_req;
    logic                    busy;
    logic                    swap_req;
    logic                    frame_end;
    logic                    swap_pending;
    logic                    swap_done;
    logic                    front_sel;
    logic [COL_W-1:0]        read_col_idx;
    logic [N_ROWS*PW-1:0]    col_bits;

    modport master (
        output write_en, pixel_addr, pixel_value, chan_mask, clear_req,
               swap_req, frame_end, read_col_idx,
        input  write_ack, busy, swap_pending, swap_done, front_sel, col_bits
    );

    modport slave (
        input  write_en, pixel_addr, pixel_value, chan_mask, clear_req,
               swap_req, frame_end, read_col_idx,
        output write_ack, busy, swap_pending, swap_done, front_sel, col_bits
    );
endinterface

// File: rtl/pixel_frame_buffer.sv
// Double-buffered RGB pixel store: masked writes and column-serial clears hit the back
// buffer, the scanner reads whole columns from the front, and swaps wait for frame_end.
module pixel_frame_buffer #(
    parameter int N_COLS           = 8,
    parameter int N_ROWS           = 8,
    parameter int BITS_PER_CHANNEL = 8,
    parameter int COL_W            = $clog2(N_COLS),
    parameter int ROW_W            = $clog2(N_ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pixel_frame_buffer_if.slave  bus
);
    localparam int PW = 3 * BITS_PER_CHANNEL;
    localparam int AW = COL_W + ROW_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state_reg;
    logic [COL_W-1:0]     clr_cnt_reg;
    logic                 front_sel_reg;
    logic                 swap_pending_reg;
    logic                 swap_done_reg;
    logic                 write_ack_reg;

    logic [COL_W-1:0]     wr_x;
    logic [ROW_W-1:0]     wr_y;
    logic                 back_sel;
    logic                 wr_accept;
    logic                 swap_fire;
    logic [N_ROWS*PW-1:0] col_flat [2][N_COLS];
    logic [N_ROWS*PW-1:0] col_bits_mux;

    assign wr_x     = bus.pixel_addr[AW-1 -: COL_W];
    assign wr_y     = bus.pixel_addr[ROW_W-1:0];
    assign back_sel = ~front_sel_reg;

    assign wr_accept = bus.write_en && (state_reg == IDLE)
                    && ({1'b0, wr_x} < (COL_W+1)'(N_COLS))
                    && ({1'b0, wr_y} < (ROW_W+1)'(N_ROWS));

    // A clear request in the same cycle wins over frame_end; the swap stays pending.
    assign swap_fire = bus.frame_end && (swap_pending_reg || bus.swap_req)
                    && (state_reg == IDLE) && !bus.clear_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            clr_cnt_reg      <= '0;
            front_sel_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            swap_done_reg    <= 1'b0;
            write_ack_reg    <= 1'b0;
        end else begin
            write_ack_reg <= wr_accept;
            swap_done_reg <= swap_fire;
            if (swap_fire) begin
                front_sel_reg    <= ~front_sel_reg;
                swap_pending_reg <= 1'b0;
            end else if (bus.swap_req) begin
                swap_pending_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.clear_req) begin
                        state_reg   <= CLEAR;
                        clr_cnt_reg <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_reg == COL_W'(N_COLS - 1)) begin
                        state_reg   <= IDLE;
                        clr_cnt_reg <= '0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One register per pixel so reset clears everything and columns read out in parallel.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        for (genvar gc = 0; gc < N_COLS; gc++) begin : g_col
            logic col_clr;
            assign col_clr = (state_reg == CLEAR) && (back_sel == 1'(gi))
                          && (clr_cnt_reg == COL_W'(gc));
            for (genvar gr = 0; gr < N_ROWS; gr++) begin : g_row
                logic [PW-1:0] pix_reg;
                logic          pix_hit;
                assign pix_hit = wr_accept && (back_sel == 1'(gi))
                              && (wr_x == COL_W'(gc)) && (wr_y == ROW_W'(gr));
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pix_reg <= '0;
                    end else if (col_clr) begin
                        pix_reg <= '0;
                    end else if (pix_hit) begin
                        for (int ch = 0; ch < 3; ch++) begin
                            if (bus.chan_mask[ch]) begin
                                pix_reg[ch*BITS_PER_CHANNEL +: BITS_PER_CHANNEL]
                                    <= bus.pixel_value[ch*BITS_PER_CHANNEL +: BITS_PER_CHANNEL];
                            end
                        end
                    end
                end
                assign col_flat[gi][gc][gr*PW +: PW] = pix_reg;
            end
        end
    end

    always_comb begin
        col_bits_mux = '0;
        for (int c = 0; c < N_COLS; c++) begin
            if ({1'b0, bus.read_col_idx} == (COL_W+1)'(c)) begin
                col_bits_mux = col_flat[front_sel_reg][c];
            end
        end
    end

    assign bus.col_bits     = col_bits_mux;
    assign bus.write_ack    = write_ack_reg;
    assign bus.busy         = (state_reg == CLEAR);
    assign bus.swap_pending = swap_pending_reg;
    assign bus.swap_done    = swap_done_reg;
    assign bus.front_sel    = front_sel_reg;
endmodule
